// File: rtl/conv_column_sequencer_pkg.sv
// Shared definitions for the convolution column sequencer.
//   - Default lane width and kernel size.
//   - Sequencer state encoding.
//   - lane_lsb(): base bit of a lane inside a packed column vector.
package conv_column_sequencer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_KERNELSIZE = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MUL = 3'd1,
        ST_NEXT_COL = 3'd2,
        ST_FINAL    = 3'd3,
        ST_OUTPUT   = 3'd4
    } seq_state_e;

    // Lane l of a packed column occupies [l*width +: width].
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/conv_kernel_regfile.sv
// K*K weight register file with a single write port and a column-wide read port.
// Ports:
//   clk, rst        clock and synchronous active-high reset (clears all weights)
//   wr_en           write strobe (caller gates it by sequencer state)
//   wr_addr/wr_data weight index c*K+l and value; indices >= K*K are dropped
//   rd_col          kernel column to present
//   rd_data         K weights of rd_col, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
module conv_kernel_regfile
    import conv_column_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned KERNELSIZE = DEF_KERNELSIZE,
    parameter int unsigned KADDR_W    = $clog2(KERNELSIZE * KERNELSIZE),
    parameter int unsigned COL_W      = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [KADDR_W-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [COL_W-1:0]                 rd_col,
    output logic [KERNELSIZE*DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = KERNELSIZE * KERNELSIZE;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [KADDR_W-1:0]    rd_idx;

    always_comb begin
        mem_d = mem_q;
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_idx  = '0;
        for (int unsigned l = 0; l < KERNELSIZE; l++) begin
            rd_idx = KADDR_W'(32'(rd_col) * KERNELSIZE + l);
            rd_data[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH] = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/conv_column_sequencer.sv
// Control/data stage feeding matrixAccelerator. Holds a KxK kernel, accepts an
// image window one column per beat, issues each column with mStart/Add pulses,
// requests the final lane reduction and buffers the result behind valid/ready.
// Ports:
//   Clk, Rst                    clock, synchronous active-high reset
//   kWrEn/kWrAddr/kWrData       kernel weight write (honoured only when idle)
//   winValid/winReady/winData   window column input handshake
//   multiplier_out              registered pixel column to the accelerator
//   multiplicand_out            registered weight column to the accelerator
//   mStart/mReady               per-lane multiply start pulse / done
//   Add                         per-lane accumulate-previous-product pulse
//   finalAdd/finalReady         final reduction request / result valid
//   finalAccumulate             window sum from the accelerator
//   accClear                    one-cycle accumulator clear after result pickup
//   resValid/resReady/resData   single-entry result buffer handshake
//   busy                        sequencer not idle
module conv_column_sequencer
    import conv_column_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned KERNELSIZE = DEF_KERNELSIZE,
    parameter int unsigned KADDR_W    = $clog2(KERNELSIZE * KERNELSIZE)
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             kWrEn,
    input  logic [KADDR_W-1:0]               kWrAddr,
    input  logic [DATA_WIDTH-1:0]            kWrData,
    input  logic                             winValid,
    output logic                             winReady,
    input  logic [KERNELSIZE*DATA_WIDTH-1:0] winData,
    output logic [KERNELSIZE*DATA_WIDTH-1:0] multiplier_out,
    output logic [KERNELSIZE*DATA_WIDTH-1:0] multiplicand_out,
    output logic [KERNELSIZE-1:0]            mStart,
    input  logic [KERNELSIZE-1:0]            mReady,
    output logic [KERNELSIZE-1:0]            Add,
    output logic                             finalAdd,
    input  logic                             finalReady,
    input  logic [2*DATA_WIDTH-1:0]          finalAccumulate,
    output logic                             accClear,
    output logic                             resValid,
    input  logic                             resReady,
    output logic [2*DATA_WIDTH-1:0]          resData,
    output logic                             busy
);

    localparam int unsigned COL_W = (KERNELSIZE > 1) ? $clog2(KERNELSIZE) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(KERNELSIZE - 1);

    seq_state_e                       state_q, state_d;
    logic [COL_W-1:0]                 col_q, col_d;
    logic [KERNELSIZE*DATA_WIDTH-1:0] mult_q, mult_d;
    logic [KERNELSIZE*DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic                             mstart_q, mstart_d;
    logic                             add_q, add_d;
    logic                             accclear_q, accclear_d;
    logic [2*DATA_WIDTH-1:0]          res_q, res_d;

    logic                             k_wr_en;
    logic [COL_W-1:0]                 k_rd_col;
    logic [KERNELSIZE*DATA_WIDTH-1:0] k_rd_data;

    // Weights may only change between windows so an in-flight window sees one kernel.
    assign k_wr_en  = kWrEn && (state_q == ST_IDLE);
    // Kernel column that pairs with a column accepted this cycle.
    assign k_rd_col = (state_q == ST_NEXT_COL) ? (col_q + COL_W'(1)) : '0;

    conv_kernel_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .KERNELSIZE (KERNELSIZE),
        .KADDR_W    (KADDR_W),
        .COL_W      (COL_W)
    ) u_kernel (
        .clk     (Clk),
        .rst     (Rst),
        .wr_en   (k_wr_en),
        .wr_addr (kWrAddr),
        .wr_data (kWrData),
        .rd_col  (k_rd_col),
        .rd_data (k_rd_data)
    );

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        mult_d     = mult_q;
        mcand_d    = mcand_q;
        res_d      = res_q;
        mstart_d   = 1'b0;
        add_d      = 1'b0;
        accclear_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (winValid) begin
                    mult_d   = winData;
                    mcand_d  = k_rd_data;
                    mstart_d = 1'b1;
                    col_d    = '0;
                    state_d  = ST_WAIT_MUL;
                end
            end
            ST_WAIT_MUL: begin
                if (&mReady) begin
                    if (col_q == LAST_COL) begin
                        // Last product has no following mStart to ride on.
                        add_d   = 1'b1;
                        state_d = ST_FINAL;
                    end else begin
                        state_d = ST_NEXT_COL;
                    end
                end
            end
            ST_NEXT_COL: begin
                if (winValid) begin
                    mult_d   = winData;
                    mcand_d  = k_rd_data;
                    mstart_d = 1'b1;
                    // Accumulate the previous column's product alongside the new start.
                    add_d    = 1'b1;
                    col_d    = col_q + COL_W'(1);
                    state_d  = ST_WAIT_MUL;
                end
            end
            ST_FINAL: begin
                if (finalReady) begin
                    res_d   = finalAccumulate;
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (resReady) begin
                    accclear_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            mult_q     <= '0;
            mcand_q    <= '0;
            mstart_q   <= 1'b0;
            add_q      <= 1'b0;
            accclear_q <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            mult_q     <= mult_d;
            mcand_q    <= mcand_d;
            mstart_q   <= mstart_d;
            add_q      <= add_d;
            accclear_q <= accclear_d;
            res_q      <= res_d;
        end
    end

    assign winReady         = (state_q == ST_IDLE) || (state_q == ST_NEXT_COL);
    assign busy             = (state_q != ST_IDLE);
    assign finalAdd         = (state_q == ST_FINAL);
    assign resValid         = (state_q == ST_OUTPUT);
    assign resData          = res_q;
    assign accClear         = accclear_q;
    assign multiplier_out   = mult_q;
    assign multiplicand_out = mcand_q;
    assign mStart           = {KERNELSIZE{mstart_q}};
    assign Add              = {KERNELSIZE{add_q}};

endmodule

// File: tb/tb_conv_column_sequencer.sv
module tb_conv_column_sequencer;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         kWrEn;
    logic [3:0]   kWrAddr;
    logic [31:0]  kWrData;
    logic         winValid;
    logic         winReady;
    logic [95:0]  winData;
    logic [95:0]  multiplier_out;
    logic [95:0]  multiplicand_out;
    logic [2:0]   mStart;
    logic [2:0]   mReady;
    logic [2:0]   Add;
    logic         finalAdd;
    logic         finalReady;
    logic [63:0]  finalAccumulate;
    logic         accClear;
    logic         resValid;
    logic         resReady;
    logic [63:0]  resData;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] sb[$];
    int          ms_cyc[$];
    logic [2:0]  ms_val[$];
    int          add_cyc[$];
    logic [2:0]  add_val[$];
    int          fa_cycles = 0;
    int          ac_cnt    = 0;

    // accelerator model state
    logic        manual_mode;
    logic [2:0]  manual_val;
    logic        mpipe;
    logic        model_mready;
    logic [1:0]  fcnt;
    logic [63:0] prod [3];
    logic [63:0] acc  [3];

    conv_column_sequencer #(
        .DATA_WIDTH (32),
        .KERNELSIZE (3)
    ) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .kWrEn            (kWrEn),
        .kWrAddr          (kWrAddr),
        .kWrData          (kWrData),
        .winValid         (winValid),
        .winReady         (winReady),
        .winData          (winData),
        .multiplier_out   (multiplier_out),
        .multiplicand_out (multiplicand_out),
        .mStart           (mStart),
        .mReady           (mReady),
        .Add              (Add),
        .finalAdd         (finalAdd),
        .finalReady       (finalReady),
        .finalAccumulate  (finalAccumulate),
        .accClear         (accClear),
        .resValid         (resValid),
        .resReady         (resReady),
        .resData          (resData),
        .busy             (busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    assign mReady = manual_mode ? manual_val : {3{model_mready}};

    // Accelerator: 2-cycle multiply, Add accumulates the previously started
    // product, final reduction answered 3 cycles after finalAdd first appears.
    always @(posedge Clk) begin
        if (Rst) begin
            mpipe        <= 1'b0;
            model_mready <= 1'b0;
            fcnt         <= '0;
            finalReady   <= 1'b0;
            finalAccumulate <= '0;
            for (int l = 0; l < 3; l++) begin
                prod[l] <= '0;
                acc[l]  <= '0;
            end
        end else begin
            mpipe        <= mStart[0];
            model_mready <= mpipe;
            for (int l = 0; l < 3; l++) begin
                if (accClear) acc[l] <= '0;
                else if (Add[l]) acc[l] <= acc[l] + prod[l];
                if (mStart[l])
                    prod[l] <= 64'(multiplier_out[l*32 +: 32]) * 64'(multiplicand_out[l*32 +: 32]);
            end
            if (finalReady) begin
                finalReady <= 1'b0;
                fcnt       <= '0;
            end else if (finalAdd) begin
                if (fcnt == 2'd2) begin
                    finalReady      <= 1'b1;
                    finalAccumulate <= acc[0] + acc[1] + acc[2];
                end
                fcnt <= fcnt + 2'd1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // protocol event logs
    always @(negedge Clk) begin
        if (mStart != 3'b000) begin
            ms_cyc.push_back(cyc);
            ms_val.push_back(mStart);
        end
        if (Add != 3'b000) begin
            add_cyc.push_back(cyc);
            add_val.push_back(Add);
        end
        if (finalAdd) fa_cycles++;
        if (accClear) ac_cnt++;
    end

    // result monitor
    always @(negedge Clk) begin
        logic [63:0] exp;
        if (!Rst && resValid && resReady) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d expected none", resData);
            end else begin
                exp = sb.pop_front();
                check("resData", resData, exp);
            end
        end
    end

    function automatic logic [95:0] col3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {c, b, a};
    endfunction

    task automatic write_kernel(input logic [3:0] addr, input logic [31:0] data);
        kWrEn   = 1'b1;
        kWrAddr = addr;
        kWrData = data;
        @(posedge Clk); #1;
        kWrEn   = 1'b0;
    endtask

    task automatic load_kernel_const(input logic [31:0] v);
        for (int i = 0; i < 9; i++) write_kernel(4'(i), v);
    endtask

    task automatic send_column(input logic [95:0] d);
        int n = 0;
        winValid = 1'b1;
        winData  = d;
        @(negedge Clk);
        while (!winReady && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!winReady) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_column_timeout: got winReady=0 expected 1 within 200 cycles");
        end
        @(posedge Clk); #1;
        winValid = 1'b0;
    endtask

    task automatic wait_results(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge Clk);
            n++;
        end
        check("result_pending", 64'(sb.size()), 64'(0));
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_winReady"}, 64'(winReady), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_resValid"}, 64'(resValid), 64'(0));
        check({tag, "_mStart"}, 64'(mStart), 64'(0));
        check({tag, "_Add"}, 64'(Add), 64'(0));
        check({tag, "_finalAdd"}, 64'(finalAdd), 64'(0));
        check({tag, "_accClear"}, 64'(accClear), 64'(0));
        check({tag, "_resData"}, resData, 64'(0));
        check({tag, "_mult_nz"}, 64'(|multiplier_out), 64'(0));
        check({tag, "_mcand_nz"}, 64'(|multiplicand_out), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst         = 1'b1;
        kWrEn       = 1'b0;
        kWrAddr     = '0;
        kWrData     = '0;
        winValid    = 1'b0;
        winData     = '0;
        resReady    = 1'b1;
        manual_mode = 1'b0;
        manual_val  = '0;

        // reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_idle_outputs("reset");
        @(posedge Clk); #1;
        Rst = 1'b0;

        // window 1: all-ones kernel, expected 1+..+9 = 45
        load_kernel_const(32'd1);
        ms_cyc.delete(); ms_val.delete(); add_cyc.delete(); add_val.delete();
        fa_cycles = 0;
        ac_cnt    = 0;
        sb.push_back(64'd45);
        send_column(col3(32'd1, 32'd2, 32'd3));
        send_column(col3(32'd4, 32'd5, 32'd6));
        send_column(col3(32'd7, 32'd8, 32'd9));
        wait_results(200);
        check("mstart_count", 64'(ms_cyc.size()), 64'(3));
        check("add_count", 64'(add_cyc.size()), 64'(3));
        if (ms_cyc.size() == 3 && add_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("mstart_value", 64'(ms_val[i]), 64'(3'b111));
                check("add_value", 64'(add_val[i]), 64'(3'b111));
            end
            check("add_with_col1", 64'(add_cyc[0]), 64'(ms_cyc[1]));
            check("add_with_col2", 64'(add_cyc[1]), 64'(ms_cyc[2]));
            check("add_trailing", 64'(add_cyc[2] > ms_cyc[2]), 64'(1));
        end
        check("finalAdd_cycles", 64'(fa_cycles), 64'(4));
        check("accClear_w1", 64'(ac_cnt), 64'(1));

        // window 2: weight 2 at index 4 only, middle lane of column 1 = 20 -> 40
        for (int i = 0; i < 9; i++) write_kernel(4'(i), (i == 4) ? 32'd2 : 32'd0);
        write_kernel(4'd9, 32'h77);
        write_kernel(4'd15, 32'h77);
        sb.push_back(64'd40);
        send_column(col3(32'd1, 32'd1, 32'd1));
        send_column(col3(32'd10, 32'd20, 32'd30));
        send_column(col3(32'd5, 32'd5, 32'd5));
        wait_results(200);

        // result held under backpressure: 2*2 = 4
        resReady = 1'b0;
        sb.push_back(64'd4);
        send_column(col3(32'd9, 32'd9, 32'd9));
        send_column(col3(32'd1, 32'd2, 32'd3));
        send_column(col3(32'd9, 32'd9, 32'd9));
        begin
            int n = 0;
            @(negedge Clk);
            while (!resValid && n < 200) begin
                @(negedge Clk);
                n++;
            end
            check("resValid_arrives", 64'(resValid), 64'(1));
        end
        ac_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            check("hold_resValid", 64'(resValid), 64'(1));
            check("hold_resData", resData, 64'd4);
            check("hold_winReady", 64'(winReady), 64'(0));
            check("hold_accClear", 64'(accClear), 64'(0));
        end
        @(posedge Clk); #1;
        resReady = 1'b1;
        wait_results(50);
        check("accClear_after_hold", 64'(ac_cnt), 64'(1));

        // kernel write while busy is dropped: 9*2 = 18, then 6*2 = 12
        sb.push_back(64'd18);
        send_column(col3(32'd7, 32'd7, 32'd7));
        check("busy_during_write", 64'(busy), 64'(1));
        write_kernel(4'd0, 32'hFFFF);
        send_column(col3(32'd3, 32'd9, 32'd4));
        send_column(col3(32'd1, 32'd1, 32'd1));
        wait_results(200);
        sb.push_back(64'd12);
        send_column(col3(32'd5, 32'd5, 32'd5));
        send_column(col3(32'd6, 32'd6, 32'd6));
        send_column(col3(32'd0, 32'd0, 32'd0));
        wait_results(200);

        // reset while waiting on column 1's multiply
        send_column(col3(32'd1, 32'd1, 32'd1));
        send_column(col3(32'd1, 32'd1, 32'd1));
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check_idle_outputs("midreset");
        @(posedge Clk); #1;
        // kernel was cleared by reset: a window now sums to 0
        sb.push_back(64'd0);
        send_column(col3(32'd1, 32'd1, 32'd1));
        @(negedge Clk);
        check("kernel_cleared", 64'(|multiplicand_out), 64'(0));
        @(posedge Clk); #1;
        send_column(col3(32'd2, 32'd2, 32'd2));
        send_column(col3(32'd3, 32'd3, 32'd3));
        wait_results(200);
        load_kernel_const(32'd1);
        sb.push_back(64'd45);
        send_column(col3(32'd1, 32'd2, 32'd3));
        send_column(col3(32'd4, 32'd5, 32'd6));
        send_column(col3(32'd7, 32'd8, 32'd9));
        wait_results(200);

        // partial mReady must not advance the sequencer: 3+6+9 = 18
        manual_mode = 1'b1;
        manual_val  = 3'b011;
        sb.push_back(64'd18);
        send_column(col3(32'd1, 32'd1, 32'd1));
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("partial_busy", 64'(busy), 64'(1));
            check("partial_winReady", 64'(winReady), 64'(0));
            check("partial_finalAdd", 64'(finalAdd), 64'(0));
        end
        @(posedge Clk); #1;
        manual_val = 3'b111;
        @(posedge Clk); #1;
        manual_mode = 1'b0;
        @(negedge Clk);
        check("full_ready_advances", 64'(winReady), 64'(1));
        @(posedge Clk); #1;
        send_column(col3(32'd2, 32'd2, 32'd2));
        send_column(col3(32'd3, 32'd3, 32'd3));
        wait_results(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_column_sequencer.md
Name: conv_column_sequencer

Overview:
- Upstream control and data stage for matrixAccelerator.
- Holds a KERNELSIZE x KERNELSIZE weight kernel and accepts image windows one column per beat.
- Issues each column to the accelerator as multiplier/multiplicand vectors with mStart/Add.
- Fires finalAdd after the last column, then captures finalAccumulate into a single-entry result buffer with valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, width of one pixel or weight lane.
- KERNELSIZE, 3, lanes per column and columns per window (K).
- KADDR_W, $clog2(KERNELSIZE*KERNELSIZE), kernel write address width.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous active-high reset.
- kWrEn  in  1  kernel weight write strobe.
- kWrAddr  in  KADDR_W  weight index; column c, lane l at c*K+l.
- kWrData  in  DATA_WIDTH  weight value.
- winValid  in  1  window column valid.
- winReady  out  1  column accepted when winValid&&winReady.
- winData  in  K*DATA_WIDTH  one window column; lane l at [l*DATA_WIDTH+:DATA_WIDTH].
- multiplier_out  out  K*DATA_WIDTH  pixel column to accelerator.
- multiplicand_out  out  K*DATA_WIDTH  weight column to accelerator.
- mStart  out  K  per-lane multiply start, one-cycle pulse.
- mReady  in  K  per-lane multiply done.
- Add  out  K  per-lane accumulate of previous product, one-cycle pulse.
- finalAdd  out  1  request final lane reduction.
- finalReady  in  1  finalAccumulate valid.
- finalAccumulate  in  2*DATA_WIDTH  window sum.
- accClear  out  1  one-cycle accelerator accumulator clear.
- resValid  out  1  result valid.
- resReady  in  1  result consumed when resValid&&resReady.
- resData  out  2*DATA_WIDTH  convolution result.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, Rst=1 at a posedge): FSM goes to IDLE, column counter 0, kernel registers 0.
  - All outputs 0 except winReady, which follows IDLE.
  - Reset mid-operation aborts the window and asserts no accClear; the integrator also resets the accelerator.
- Kernel writes occur only in IDLE. kWrEn in any other state is ignored. An out-of-range kWrAddr (>=K*K) is ignored.
- States:
  - IDLE: winReady=1 and resValid=0. On accept, latch the column into multiplier_out, load kernel column 0 into multiplicand_out, pulse mStart=all-ones next cycle, col=0 → WAIT_MUL.
  - WAIT_MUL: winReady=0. Wait for mReady==all-ones (partial mReady is ignored).
    - col<K-1 → NEXT_COL.
    - col==K-1 → the cycle after mReady, pulse Add=all-ones for the last product → FINAL.
  - NEXT_COL: winReady=1. On accept, latch the column and kernel column col+1. Next cycle pulse mStart=all-ones, plus Add=all-ones if col>=0. Increment col → WAIT_MUL. No timeout.
  - FINAL: finalAdd=1, held until finalReady. On finalReady, capture finalAccumulate into resData, finalAdd=0 → OUTPUT.
  - OUTPUT: resValid=1, resData stable. On resReady, resValid=0, pulse accClear one cycle → IDLE.
- Column 0 never asserts Add. Each column k>=1 asserts Add on the same cycle as its mStart. The last column's product is added in a separate Add pulse.
- A finalReady or mReady arriving in an unexpected state is ignored.
- Backpressure: the next window is not accepted until the result is consumed.
- Minimum window latency is 2K+3 cycles plus accelerator latency.
- resData is exactly finalAccumulate, with no truncation or sign handling in this block.

Decomposition:
- Shared package/header (definitions.h): KERNELSIZE, the state encoding localparams (IDLE, WAIT_MUL, NEXT_COL, FINAL, OUTPUT), and the lane slice macro.
- One sub-module: conv_kernel_regfile (K*K x DATA_WIDTH write-port register file with a column-wide read port). The FSM and handshakes stay in the top.

Test Plan:
- K=3, kernel all 1, columns {1,2,3},{4,5,6},{7,8,9}, accelerator model with 2-cycle multiply latency → resData=45.
  - Check mStart pulses at 3 points.
  - Check Add coincides with mStart for columns 1 and 2, plus the trailing pulse.
  - Check finalAdd held until finalReady.
- Kernel with weight 2 at index 4, others 0, window column 1 = {10,20,30} → resData=40.
- resReady held low 20 cycles → resValid and resData stable, winReady=0 throughout, then one accClear pulse after the handshake.
- kWrEn to index 0 with 0xFFFF while busy → kernel unchanged; the next window result matches the old kernel.
- Rst asserted while in WAIT_MUL of column 1 → next cycle all outputs 0, busy=0, winReady=1; a fresh window computes correctly with the kernel re-loaded.
- mReady=3'b011 for 5 cycles, then 3'b111 → no progression until all lanes ready.
